// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: control FSM encoding, default widths and
// the flush-counter reload helper used by the pipeline control block.
package pipe_ctrl_pkg;

    localparam int N_REGS_DEF  = 32;
    localparam int RF_SIZE_DEF = 5;
    localparam int OP_SIZE     = 4;
    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pipe_state_e;

    // Value loaded into the flush counter: FLUSH-state cycles still to come
    // after the cycle that accepted the flush.
    function automatic logic [FLUSH_CNT_W-1:0] flush_reload(input int cycles);
        return FLUSH_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, set when an
// instruction that writes it issues and cleared when writeback retires it.
// Hazard detection reads only the registered bits (no same-cycle bypass).
module scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int N_REGS  = N_REGS_DEF,
    parameter int RF_SIZE = $clog2(N_REGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_set_en,
    input  logic [RF_SIZE-1:0] i_set_idx,
    input  logic               i_clr_en,
    input  logic [RF_SIZE-1:0] i_clr_idx,
    input  logic               i_id_valid,
    input  logic [RF_SIZE-1:0] i_rs1,
    input  logic               i_rs1_used,
    input  logic [RF_SIZE-1:0] i_rs2,
    input  logic               i_rs2_used,
    input  logic [RF_SIZE-1:0] i_rd,
    input  logic               i_reg_write,
    output logic               o_hazard,
    output logic               o_busy
);

    logic [N_REGS-1:0] r_pending;
    logic [N_REGS-1:0] w_pending_nxt;

    // Next pending vector: clear first, then set, so a same-cycle set wins; x0 never pends.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_en && (i_clr_idx != '0)) begin
            w_pending_nxt[i_clr_idx] = 1'b0;
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
        if (i_set_en && (i_set_idx != '0)) begin
            w_pending_nxt[i_set_idx] = 1'b1;
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Pending-bit register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_hazard = i_id_valid &
                      ((i_rs1_used  & r_pending[i_rs1]) |
                       (i_rs2_used  & r_pending[i_rs2]) |
                       (i_reg_write & r_pending[i_rd]));

    assign o_busy = |r_pending;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline front-end control: RUN/FLUSH FSM, flush bubble counter, saturating
// hazard-stall counter, and the register scoreboard that detects RAW/WAW hazards.
// Stage enables are combinational from registered state so they act this cycle.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int N_REGS       = N_REGS_DEF,
    parameter int RF_SIZE      = $clog2(N_REGS),
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [RF_SIZE-1:0] id_rs1,
    input  logic [RF_SIZE-1:0] id_rs2,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic [RF_SIZE-1:0] id_rd,
    input  logic               id_reg_write,
    input  logic               wb_valid,
    input  logic [RF_SIZE-1:0] wb_rd,
    input  logic               ex_stall_req,
    input  logic               flush_req,
    output logic               if_en,
    output logic               id_en,
    output logic               id_bubble,
    output logic               busy,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD  = flush_reload(FLUSH_CYCLES);
    localparam bit                     FLUSH_MULTI = (FLUSH_CYCLES > 1);

    pipe_state_e            r_state;
    pipe_state_e            w_state_nxt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic [FLUSH_CNT_W-1:0] w_flush_cnt_nxt;
    logic [CNT_W-1:0]       r_stall_cnt;
    logic [CNT_W-1:0]       w_stall_cnt_nxt;
    logic                   w_if_en;
    logic                   w_id_en;
    logic                   w_id_bubble;
    logic                   w_issue;
    logic                   w_hazard;
    logic                   w_sb_busy;

    assign w_issue = id_valid & w_id_en & ~w_id_bubble;

    scoreboard #(
        .N_REGS  (N_REGS),
        .RF_SIZE (RF_SIZE)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set_en    (w_issue & id_reg_write),
        .i_set_idx   (id_rd),
        .i_clr_en    (wb_valid),
        .i_clr_idx   (wb_rd),
        .i_id_valid  (id_valid),
        .i_rs1       (id_rs1),
        .i_rs1_used  (id_rs1_used),
        .i_rs2       (id_rs2),
        .i_rs2_used  (id_rs2_used),
        .i_rd        (id_rd),
        .i_reg_write (id_reg_write),
        .o_hazard    (w_hazard),
        .o_busy      (w_sb_busy)
    );

    // Next-state, counter updates and stage enables; reset forces a held, bubbled front end.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_stall_cnt_nxt = r_stall_cnt;
        w_if_en         = 1'b0;
        w_id_en         = 1'b0;
        w_id_bubble     = 1'b1;
        if (!rst_n) begin
            w_state_nxt     = ST_RUN;
            w_flush_cnt_nxt = '0;
            w_stall_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (flush_req) begin
                        w_if_en     = 1'b1;
                        w_id_en     = 1'b1;
                        w_id_bubble = 1'b1;
                        if (FLUSH_MULTI) begin
                            w_state_nxt     = ST_FLUSH;
                            w_flush_cnt_nxt = FLUSH_LOAD;
                        end else begin
                            w_state_nxt     = ST_RUN;
                            w_flush_cnt_nxt = '0;
                        end
                    end else if (ex_stall_req) begin
                        w_if_en     = 1'b0;
                        w_id_en     = 1'b0;
                        w_id_bubble = 1'b0;
                    end else if (w_hazard) begin
                        w_if_en     = 1'b0;
                        w_id_en     = 1'b1;
                        w_id_bubble = 1'b1;
                        if (r_stall_cnt != '1) begin
                            w_stall_cnt_nxt = r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            w_stall_cnt_nxt = r_stall_cnt;
                        end
                    end else begin
                        w_if_en     = 1'b1;
                        w_id_en     = 1'b1;
                        w_id_bubble = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_req) begin
                        w_if_en     = 1'b1;
                        w_id_en     = 1'b1;
                        w_id_bubble = 1'b1;
                        if (FLUSH_MULTI) begin
                            w_state_nxt     = ST_FLUSH;
                            w_flush_cnt_nxt = FLUSH_LOAD;
                        end else begin
                            w_state_nxt     = ST_RUN;
                            w_flush_cnt_nxt = '0;
                        end
                    end else if (ex_stall_req) begin
                        w_if_en     = 1'b0;
                        w_id_en     = 1'b0;
                        w_id_bubble = 1'b1;
                    end else begin
                        w_if_en     = 1'b1;
                        w_id_en     = 1'b1;
                        w_id_bubble = 1'b1;
                        // Counter holds remaining FLUSH cycles; leave when this is the last one.
                        if (r_flush_cnt <= 4'd1) begin
                            w_state_nxt     = ST_RUN;
                            w_flush_cnt_nxt = '0;
                        end else begin
                            w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State, flush counter and stall counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign if_en     = w_if_en;
    assign id_en     = w_id_en;
    assign id_bubble = w_id_bubble;
    assign busy      = rst_n & w_sb_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a register-set / remaining-bubble model
// checked every cycle, plus literal expectations at key scenario points.
module tb_pipe_ctrl;

    localparam int NR  = 32;
    localparam int RW  = 5;
    localparam int FC  = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [RW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic          id_rs1_used, id_rs2_used, id_reg_write;
    logic          wb_valid, ex_stall_req, flush_req;
    logic          if_en, id_en, id_bubble, busy;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(
        .N_REGS       (NR),
        .RF_SIZE      (RW),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .ex_stall_req (ex_stall_req),
        .flush_req    (flush_req),
        .if_en        (if_en),
        .id_en        (id_en),
        .id_bubble    (id_bubble),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_pend [NR];
    int m_left  = 0;   // bubble cycles still owed after the current one
    int m_stall = 0;
    int maxcnt  = (1 << CW) - 1;

    always @(negedge clk) begin
        bit e_if, e_id, e_b, e_busy, haz, iss;
        e_busy = 1'b0;
        for (int i = 0; i < NR; i++) if (m_pend[i]) e_busy = 1'b1;
        if (!rst_n) begin
            e_if = 0; e_id = 0; e_b = 1; e_busy = 0;
        end else begin
            haz = id_valid && ((id_rs1_used && m_pend[id_rs1]) ||
                               (id_rs2_used && m_pend[id_rs2]) ||
                               (id_reg_write && m_pend[id_rd]));
            if (flush_req)          begin e_if = 1; e_id = 1; e_b = 1; end
            else if (m_left > 0)    begin e_if = !ex_stall_req; e_id = !ex_stall_req; e_b = 1; end
            else if (ex_stall_req)  begin e_if = 0; e_id = 0; e_b = 0; end
            else if (haz)           begin e_if = 0; e_id = 1; e_b = 1; end
            else                    begin e_if = 1; e_id = 1; e_b = 0; end
        end
        chk("if_en", int'(if_en), int'(e_if));
        chk("id_en", int'(id_en), int'(e_id));
        chk("id_bubble", int'(id_bubble), int'(e_b));
        chk("busy", int'(busy), int'(e_busy));
        chk("stall_cnt", int'(stall_cnt), m_stall);
        // advance model to the following edge
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
            m_left = 0; m_stall = 0;
        end else begin
            iss = id_valid && e_id && !e_b;
            if (flush_req) m_left = FC - 1;
            else if (m_left > 0) begin
                if (!ex_stall_req) m_left--;
            end else if (!ex_stall_req && haz && m_stall < maxcnt) m_stall++;
            if (wb_valid) m_pend[wb_rd] = 1'b0;
            if (iss && id_reg_write) m_pend[id_rd] = 1'b1;
            m_pend[0] = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 0; id_rs2_used = 0; id_reg_write = 0;
        wb_valid = 0; wb_rd = '0; ex_stall_req = 0; flush_req = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input int rd);
        idle(); id_valid = 1; id_rd = RW'(rd); id_reg_write = 1;
    endtask

    task automatic read_rs1(input int rs);
        idle(); id_valid = 1; id_rs1 = RW'(rs); id_rs1_used = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        nxt(); nxt();
        #6;
        chk("lit_rst_if_en", int'(if_en), 0);
        chk("lit_rst_bubble", int'(id_bubble), 1);
        chk("lit_rst_busy", int'(busy), 0);
        nxt();
        rst_n = 1'b1;

        // RAW hazard on x5, cleared by writeback
        issue_wr(5); #6;
        chk("lit_issue_if_en", int'(if_en), 1);
        chk("lit_issue_bubble", int'(id_bubble), 0);
        nxt();
        read_rs1(5); #6;
        chk("lit_haz_if_en", int'(if_en), 0);
        chk("lit_haz_bubble", int'(id_bubble), 1);
        chk("lit_haz_busy", int'(busy), 1);
        nxt();
        read_rs1(5); wb_valid = 1; wb_rd = 5'd5; #6;
        chk("lit_stall_cnt_1", int'(stall_cnt), 1);
        chk("lit_no_bypass_if_en", int'(if_en), 0);
        nxt();
        read_rs1(5); #6;
        chk("lit_release_if_en", int'(if_en), 1);
        chk("lit_release_bubble", int'(id_bubble), 0);
        chk("lit_release_busy", int'(busy), 0);
        nxt();

        // x0 never pends
        issue_wr(0); nxt();
        read_rs1(0); id_rs2_used = 1; #6;
        chk("lit_x0_if_en", int'(if_en), 1);
        chk("lit_x0_busy", int'(busy), 0);
        nxt();

        // single flush keeps scoreboard intact
        issue_wr(9); nxt();
        idle(); flush_req = 1; #6;
        chk("lit_flush0_bubble", int'(id_bubble), 1);
        chk("lit_flush0_if_en", int'(if_en), 1);
        nxt();
        idle(); #6;
        chk("lit_flush1_bubble", int'(id_bubble), 1);
        chk("lit_flush1_if_en", int'(if_en), 1);
        nxt();
        idle(); #6;
        chk("lit_flush_done_bubble", int'(id_bubble), 0);
        chk("lit_flush_busy", int'(busy), 1);
        nxt();
        read_rs1(9); wb_valid = 1; wb_rd = 5'd9; #6;
        chk("lit_post_flush_haz", int'(if_en), 0);
        nxt();
        idle(); nxt();

        // priority: flush over ex_stall over hazard
        issue_wr(11); nxt();
        read_rs1(11); flush_req = 1; ex_stall_req = 1; #6;
        chk("lit_prio_if_en", int'(if_en), 1);
        chk("lit_prio_id_en", int'(id_en), 1);
        chk("lit_prio_bubble", int'(id_bubble), 1);
        chk("lit_prio_stall", int'(stall_cnt), 3);
        nxt();
        idle(); ex_stall_req = 1; #6;
        chk("lit_flush_hold_if_en", int'(if_en), 0);
        chk("lit_flush_hold_bubble", int'(id_bubble), 1);
        nxt();
        idle(); nxt();
        read_rs1(11); ex_stall_req = 1; #6;
        chk("lit_exs_if_en", int'(if_en), 0);
        chk("lit_exs_id_en", int'(id_en), 0);
        chk("lit_exs_bubble", int'(id_bubble), 0);
        nxt();
        idle(); wb_valid = 1; wb_rd = 5'd11; #6;
        chk("lit_exs_stall_same", int'(stall_cnt), 3);
        nxt();

        // same-cycle set and clear of x7: set wins; then saturate
        issue_wr(7); wb_valid = 1; wb_rd = 5'd7; nxt();
        for (int k = 0; k < 20; k++) begin
            idle(); id_valid = 1; id_rs2 = 5'd7; id_rs2_used = 1;
            if (k == 0) begin
                #6; chk("lit_set_wins", int'(if_en), 0);
            end
            nxt();
        end
        idle(); wb_valid = 1; wb_rd = 5'd7; #6;
        chk("lit_stall_sat", int'(stall_cnt), 15);
        nxt();

        // back-to-back flushes reload the counter
        idle(); flush_req = 1; nxt();
        idle(); flush_req = 1; nxt();
        idle(); nxt();
        idle(); nxt();

        // reset during FLUSH with x3 pending
        issue_wr(3); nxt();
        idle(); flush_req = 1; nxt();
        idle(); rst_n = 1'b0; nxt();
        rst_n = 1'b1; idle(); #6;
        chk("lit_rel_if_en", int'(if_en), 1);
        chk("lit_rel_bubble", int'(id_bubble), 0);
        chk("lit_rel_busy", int'(busy), 0);
        chk("lit_rel_stall", int'(stall_cnt), 0);
        nxt();
        read_rs1(3); nxt();
        idle(); nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter N_REGS, default 32, number of architectural registers.
REQ-002 Parameter RF_SIZE, default $clog2(N_REGS), register index width.
REQ-003 Parameter FLUSH_CYCLES, default 2, bubble cycles inserted per flush (legal range 1..15).
REQ-004 Parameter CNT_W, default 16, stall counter width.
REQ-005 Port list, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1  in  RF_SIZE  source register 1.
- id_rs2  in  RF_SIZE  source register 2.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  RF_SIZE  destination register.
- id_reg_write  in  1  instruction writes rd.
- wb_valid  in  1  writeback retiring a register write this cycle.
- wb_rd  in  RF_SIZE  register being retired.
- ex_stall_req  in  1  EX busy; freeze front end.
- flush_req  in  1  redirect; kill instruction in ID.
- if_en  out  1  IF/ID register enable.
- id_en  out  1  ID/EX register enable (drives decode-stage en).
- id_bubble  out  1  force ID/EX controls to zero this cycle.
- busy  out  1  any scoreboard bit set.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-006 Scoreboard: N_REGS pending bits; bit 0 SHALL always read 0.
REQ-007 Issue = id_valid & id_en & ~id_bubble; on issue with id_reg_write and id_rd!=0, pending[id_rd] SHALL set at the next edge.
REQ-008 wb_valid with wb_rd!=0 SHALL clear pending[wb_rd] at the next edge; simultaneous set and clear of the same register: set wins.
REQ-009 Hazard (combinational, from registered pending): id_valid & ((id_rs1_used & pending[id_rs1]) | (id_rs2_used & pending[id_rs2]) | (id_reg_write & pending[id_rd])); no same-cycle wb bypass.
REQ-010 FSM states RUN, FLUSH; reset state RUN.
REQ-011 Priority per cycle: flush_req > ex_stall_req > hazard > normal.
REQ-012 RUN, flush_req=1: if_en=1, id_en=1, id_bubble=1; go FLUSH with counter=FLUSH_CYCLES-1; if FLUSH_CYCLES=1 stay RUN.
REQ-013 RUN, ex_stall_req=1 (no flush): if_en=0, id_en=0, id_bubble=0.
REQ-014 RUN, hazard (no flush, no ex_stall): if_en=0, id_en=1, id_bubble=1; stall_cnt increments, saturating at all-ones.
REQ-015 RUN, none of the above: if_en=1, id_en=1, id_bubble=0.
REQ-016 FLUSH: if_en=1, id_en=1, id_bubble=1, no issue; counter decrements; at counter=0 return to RUN next edge; new flush_req in FLUSH reloads counter to FLUSH_CYCLES-1; ex_stall_req in FLUSH holds counter and drives if_en=0, id_en=0.
REQ-017 Flush SHALL NOT clear scoreboard bits; older in-flight writes retire normally.
REQ-018 busy = OR of pending bits, registered-state derived, no extra latency.

Reset
REQ-019 rst_n=0 at an edge: pending all 0, state RUN, flush counter 0, stall_cnt 0.
REQ-020 While rst_n=0: if_en=0, id_en=0, id_bubble=1, busy=0.
REQ-021 Reset mid-stall or mid-flush SHALL abandon the operation; first cycle after release behaves as RUN with empty scoreboard.

Structure
REQ-022 FSM state encoding and ALU/pipeline control widths (OP_SIZE, RF_SIZE defaults) SHALL live in the shared pipeline package.
REQ-023 The scoreboard (REQ-006..009, REQ-018) SHALL be a sub-module named scoreboard; FSM and counters stay in pipe_ctrl.

Verification
REQ-024 Issue ADDI rd=5, next cycle rs1=5 used -> hazard: if_en=0, id_bubble=1, stall_cnt=1; wb_rd=5 -> next cycle if_en=1, id_bubble=0.
REQ-025 rd=0 issue then read x0 -> no stall, pending[0]=0, busy=0.
REQ-026 flush_req one cycle, FLUSH_CYCLES=2 -> id_bubble=1 for exactly 2 cycles, if_en=1 throughout, pending bits unchanged.
REQ-027 flush_req, ex_stall_req, hazard all asserted -> flush response only; ex_stall+hazard -> if_en=0, id_en=0, stall_cnt unchanged.
REQ-028 Same-cycle issue rd=7 and wb_rd=7 -> pending[7]=1 afterwards; CNT_W=4 held in hazard 20 cycles -> stall_cnt=15.
REQ-029 rst_n=0 during FLUSH with pending[3]=1 -> after release state RUN, busy=0, stall_cnt=0, if_en=1.
